apb_master_initiator: RTL and testbench

//  APB initiator (master) for one target. Accepts single read/write requests on a

---
 rtl/apb_master_initiator_pkg.sv | 36 +++
 rtl/apb_master_initiator.sv | 133 +++++++++++++
 tb/tb_apb_master_initiator.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_initiator_pkg.sv
// Shared APB definitions: request/response bundles, response-status constants and read-data rule.
package apb_master_initiator_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] paddr;
    logic                  penable;
    logic                  psel;
    logic                  pwrite;
    logic [APB_DATA_W-1:0] pwdata;
  } t_apb_request;

  typedef struct packed {
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  perr;
  } t_apb_response;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } t_resp;

  localparam logic [APB_DATA_W-1:0] APB_RDATA_NONE = '0;
  localparam logic                  APB_ERR_SET    = 1'b1;
  localparam logic                  APB_TIMEOUT_SET = 1'b1;

  // Read data is only forwarded for reads that the target did not flag as failed.
  function automatic logic [APB_DATA_W-1:0] apb_read_data(input logic write, input t_apb_response rsp);
    return (!write && !rsp.perr) ? rsp.prdata : APB_RDATA_NONE;
  endfunction

endpackage

// File: rtl/apb_master_initiator.sv
// Single-target APB initiator: valid/ready request in, SETUP/ACCESS on APB, one-cycle response pulse out.
// Response arrives one cycle after pready (or after TIMEOUT_CYCLES waited ACCESS cycles); no response backpressure.
module apb_master_initiator
  import apb_master_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_timeout,
  output logic [31:0] apb_request__paddr,
  output logic        apb_request__penable,
  output logic        apb_request__psel,
  output logic        apb_request__pwrite,
  output logic [31:0] apb_request__pwdata,
  input  logic [31:0] apb_response__prdata,
  input  logic        apb_response__pready,
  input  logic        apb_response__perr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } t_state;

  localparam bit                       TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE    = TIMEOUT_WIDTH'(1);

  t_state                   state_q, state_d;
  t_apb_request             apb_q, apb_d;
  t_resp                    resp_q, resp_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  t_apb_response            apb_rsp;

  assign apb_rsp.prdata = apb_response__prdata;
  assign apb_rsp.pready = apb_response__pready;
  assign apb_rsp.perr   = apb_response__perr;

  always_comb begin
    state_d      = state_q;
    apb_d        = apb_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          apb_d.paddr   = req_address;
          apb_d.pwrite  = req_write;
          apb_d.pwdata  = req_wdata;
          apb_d.psel    = 1'b1;
          apb_d.penable = 1'b0;
          state_d       = ST_SETUP;
        end
      end

      ST_SETUP: begin
        apb_d.penable = 1'b1;
        cnt_d         = '0;
        state_d       = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready is checked first so a completion on the expiry cycle is not reported as a timeout.
        if (apb_rsp.pready) begin
          apb_d.psel     = 1'b0;
          apb_d.penable  = 1'b0;
          resp_valid_d   = 1'b1;
          resp_d.rdata   = apb_read_data(apb_q.pwrite, apb_rsp);
          resp_d.err     = apb_rsp.perr;
          resp_d.timeout = 1'b0;
          state_d        = ST_IDLE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          apb_d.psel     = 1'b0;
          apb_d.penable  = 1'b0;
          resp_valid_d   = 1'b1;
          resp_d.rdata   = APB_RDATA_NONE;
          resp_d.err     = APB_ERR_SET;
          resp_d.timeout = APB_TIMEOUT_SET;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      apb_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else if (clk__enable) begin
      state_q      <= state_d;
      apb_q        <= apb_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready            = (state_q == ST_IDLE);
  assign resp_valid           = resp_valid_q;
  assign resp_rdata           = resp_q.rdata;
  assign resp_err             = resp_q.err;
  assign resp_timeout         = resp_q.timeout;
  assign apb_request__paddr   = apb_q.paddr;
  assign apb_request__penable = apb_q.penable;
  assign apb_request__psel    = apb_q.psel;
  assign apb_request__pwrite  = apb_q.pwrite;
  assign apb_request__pwdata  = apb_q.pwdata;

endmodule

// File: tb/tb_apb_master_initiator.sv
// Bench for apb_master_initiator: APB target model with wait states, perr and never-ready, plus response scoreboard.
module tb_apb_master_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        clk_en;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] paddr;
  logic        penable;
  logic        psel;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        perr;

  always #5 clk = ~clk;

  apb_master_initiator #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)) dut (
    .clk                  (clk),
    .clk__enable          (clk_en),
    .reset_n              (rst_n),
    .req_valid            (req_valid),
    .req_write            (req_write),
    .req_address          (req_address),
    .req_wdata            (req_wdata),
    .req_ready            (req_ready),
    .resp_valid           (resp_valid),
    .resp_rdata           (resp_rdata),
    .resp_err             (resp_err),
    .resp_timeout         (resp_timeout),
    .apb_request__paddr   (paddr),
    .apb_request__penable (penable),
    .apb_request__psel    (psel),
    .apb_request__pwrite  (pwrite),
    .apb_request__pwdata  (pwdata),
    .apb_response__prdata (prdata),
    .apb_response__pready (pready),
    .apb_response__perr   (perr)
  );

  // Target model
  int          tgt_waits = 0;
  bit          tgt_never = 0;
  bit          tgt_perr = 0;
  bit          tgt_perr_wait = 0;
  logic [31:0] tgt_rdata = 32'h0;
  int          wcnt = 0;
  logic        in_access;

  assign in_access = psel && penable;
  assign pready    = in_access && !tgt_never && (wcnt == tgt_waits);
  assign perr      = in_access && (pready ? tgt_perr : tgt_perr_wait);
  assign prdata    = tgt_rdata ^ paddr;

  always @(posedge clk) begin
    if (clk_en) begin
      if (in_access && !pready) wcnt <= wcnt + 1;
      else                      wcnt <= 0;
    end
  end

  // Monitors
  int resp_cnt = 0;
  int access_cycles = 0;
  int stab_err = 0;
  int low_run = 0;
  bit seen_high = 0;
  int gaps[$];
  logic [31:0] h_addr, h_wdata;
  logic        h_write;
  bit          held = 0;

  always @(posedge clk) begin
    if (clk_en && rst_n) begin
      if (resp_valid) resp_cnt++;
      if (in_access)  access_cycles++;
    end
  end

  always @(negedge clk) begin
    if (psel) begin
      if (held && (paddr !== h_addr || pwrite !== h_write || pwdata !== h_wdata)) stab_err++;
      h_addr  = paddr;
      h_write = pwrite;
      h_wdata = pwdata;
      held    = 1;
    end else begin
      held = 0;
    end
    if (rst_n) begin
      if (psel) begin
        if (seen_high && low_run > 0) gaps.push_back(low_run);
        seen_high = 1;
        low_run   = 0;
      end else begin
        low_run++;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input bit wr, input logic [31:0] a);
    exp_t e;
    if (tgt_never || tgt_waits >= TO) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.to    = 1'b1;
    end else begin
      e.err   = tgt_perr;
      e.to    = 1'b0;
      e.rdata = (!wr && !tgt_perr) ? (tgt_rdata ^ a) : 32'h0;
    end
    return e;
  endfunction

  task automatic drive_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit push);
    int n = 0;
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_wdata   = d;
    if (push) sb.push_back(model(wr, a));
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept: req_ready=%b required 1 within 40 cycles", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input int budget);
    int   n = 0;
    exp_t e;
    while (resp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_resp: resp_valid not seen within %0d cycles", nm, budget);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_resp: resp_valid seen with no outstanding request", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (resp_rdata !== e.rdata) begin
        errors++;
        $display("FAIL %s_rdata: got %h required %h", nm, resp_rdata, e.rdata);
      end
      checks++;
      if (resp_err !== e.err) begin
        errors++;
        $display("FAIL %s_err: got %b required %b", nm, resp_err, e.err);
      end
      checks++;
      if (resp_timeout !== e.to) begin
        errors++;
        $display("FAIL %s_timeout: got %b required %b", nm, resp_timeout, e.to);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    checks++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      errors++; $display("FAIL reset_apb_ctrl: psel/penable/pwrite=%b required 000", {psel, penable, pwrite});
    end
    checks++;
    if ({paddr, pwdata} !== 64'h0) begin errors++; $display("FAIL reset_apb_data: got %h required 0", {paddr, pwdata}); end
    checks++;
    if ({resp_valid, resp_err, resp_timeout} !== 3'b000 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: valid/err/to=%b rdata=%h required all 0", {resp_valid, resp_err, resp_timeout}, resp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    tgt_waits = 0; tgt_perr = 0; tgt_perr_wait = 0; tgt_never = 0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_idle_ready: got %b required 1", req_ready); end
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h4; req_wdata = 32'h1234_5678;
    sb.push_back(model(1'b1, 32'h4));
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({psel, penable, req_ready} !== 3'b100) begin
      errors++; $display("FAIL wr_setup: psel/penable/req_ready=%b required 100", {psel, penable, req_ready});
    end
    checks++;
    if (paddr !== 32'h4 || pwdata !== 32'h1234_5678 || pwrite !== 1'b1) begin
      errors++; $display("FAIL wr_setup_bus: paddr=%h pwdata=%h pwrite=%b required 4 12345678 1", paddr, pwdata, pwrite);
    end
    @(negedge clk);
    checks++;
    if ({psel, penable, resp_valid} !== 3'b110) begin
      errors++; $display("FAIL wr_access: psel/penable/resp_valid=%b required 110", {psel, penable, resp_valid});
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, psel, penable, req_ready} !== 4'b1001) begin
      errors++; $display("FAIL wr_complete: resp_valid/psel/penable/req_ready=%b required 1001", {resp_valid, psel, penable, req_ready});
    end
    collect("wr", 2);
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse: resp_valid=%b required 0 one cycle later", resp_valid); end
  endtask

  task automatic test_read_waits();
    int a0 = access_cycles;
    int s0 = stab_err;
    int n = 0;
    tgt_waits = 3; tgt_rdata = 32'h0000_00AB;
    drive_req(1'b0, 32'h0, 32'h0, 1'b1);
    while (!(in_access && pready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_after_pready: resp_valid=%b required 1", resp_valid); end
    collect("rd", 2);
    checks++;
    if (access_cycles - a0 !== 4) begin errors++; $display("FAIL rd_access_len: got %0d required 4", access_cycles - a0); end
    checks++;
    if (stab_err !== s0) begin errors++; $display("FAIL rd_stable: %0d bus changes while psel high, required 0", stab_err - s0); end
  endtask

  task automatic test_back_to_back();
    int g0 = gaps.size();
    int r0 = resp_cnt;
    tgt_waits = 0; tgt_rdata = 32'h1000_0000;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_req(1'b0, 32'h100 + 32'(i * 4), 32'h0, 1'b1);
      end
      begin
        for (int j = 0; j < 4; j++) collect("b2b", 30);
      end
    join
    checks++;
    if (resp_cnt - r0 !== 4) begin errors++; $display("FAIL b2b_count: got %0d pulses required 4", resp_cnt - r0); end
    checks++;
    if (gaps.size() - g0 < 3) begin
      errors++; $display("FAIL b2b_gaps: got %0d psel gaps required at least 3", gaps.size() - g0);
    end else begin
      for (int k = gaps.size() - 3; k < gaps.size(); k++) begin
        checks++;
        if (gaps[k] !== 1) begin errors++; $display("FAIL b2b_gap_len: got %0d cycles required 1", gaps[k]); end
      end
    end
  endtask

  task automatic test_perr();
    tgt_waits = 1; tgt_perr = 1; tgt_perr_wait = 0; tgt_rdata = 32'h7777_0000;
    drive_req(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1);
    collect("perr_wr", 20);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL perr_idle: req_ready=%b required 1", req_ready); end
    tgt_waits = 3; tgt_perr = 0; tgt_perr_wait = 1; tgt_rdata = 32'h0000_0055;
    drive_req(1'b0, 32'h30, 32'h0, 1'b1);
    collect("perr_wait", 20);
    tgt_perr_wait = 0;
  endtask

  task automatic test_timeout();
    int a0 = access_cycles;
    tgt_never = 1; tgt_waits = 0;
    drive_req(1'b0, 32'h40, 32'h0, 1'b1);
    collect("to_abort", 40);
    checks++;
    if (access_cycles - a0 !== TO) begin errors++; $display("FAIL to_abort_len: got %0d required %0d", access_cycles - a0, TO); end
    tgt_never = 0; tgt_waits = TO - 1; tgt_rdata = 32'hC0DE_0000;
    a0 = access_cycles;
    drive_req(1'b0, 32'h48, 32'h0, 1'b1);
    collect("to_edge", 40);
    checks++;
    if (access_cycles - a0 !== TO) begin errors++; $display("FAIL to_edge_len: got %0d required %0d", access_cycles - a0, TO); end
  endtask

  task automatic test_reset_mid();
    int r0 = resp_cnt;
    tgt_never = 1;
    drive_req(1'b1, 32'h50, 32'hAAAA_5555, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (penable !== 1'b1) begin errors++; $display("FAIL rst_mid_access: penable=%b required 1 before reset", penable); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable} !== 2'b00) begin errors++; $display("FAIL rst_mid_async: psel/penable=%b required 00", {psel, penable}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tgt_never = 0;
    repeat (12) @(negedge clk);
    checks++;
    if (resp_cnt !== r0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_noresp: %0d pulses seen required 0", resp_cnt - r0);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_clk_enable();
    int a0 = access_cycles;
    int r0 = resp_cnt;
    tgt_waits = 2; tgt_rdata = 32'h0BAD_F00D;
    drive_req(1'b0, 32'h44, 32'h0, 1'b1);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b10) begin errors++; $display("FAIL cen_setup_hold: psel/penable=%b required 10", {psel, penable}); end
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, penable, resp_valid} !== 3'b110) begin
      errors++; $display("FAIL cen_access_hold: psel/penable/resp_valid=%b required 110", {psel, penable, resp_valid});
    end
    clk_en = 1'b1;
    collect("cen", 20);
    checks++;
    if (access_cycles - a0 !== 3) begin errors++; $display("FAIL cen_access_len: got %0d required 3", access_cycles - a0); end
    checks++;
    if (resp_cnt - r0 !== 1) begin errors++; $display("FAIL cen_pulses: got %0d required 1", resp_cnt - r0); end
  endtask

  initial begin
    clk_en = 1'b1; rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read_waits();
    test_back_to_back();
    test_perr();
    test_timeout();
    test_reset_mid();
    test_clk_enable();
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL bus_stability: %0d changes while psel high, required 0", stab_err); end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
